// File: rtl/apuf_pkg.sv
// Shared types and defaults for the arbiter-PUF evaluation controller.
// Holds the FSM state enum and the counter-width helper.
package apuf_pkg;

    localparam int unsigned DEF_NSTAGES = 64;
    localparam int unsigned DEF_NEVAL   = 7;
    localparam int unsigned DEF_SETTLE  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StLaunch,
        StWait,
        StSample,
        StClear,
        StDone
    } state_e;

    // Bits needed to hold values 0..maxval.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval < 1) ? 1 : $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/apuf_eval_ctrl_if.sv
// Challenge/response handshake plus delay-chain control bundle.
// The slave modport is the controller side.
interface apuf_eval_ctrl_if
    import apuf_pkg::*;
#(
    parameter int unsigned NSTAGES = DEF_NSTAGES,
    parameter int unsigned NEVAL   = DEF_NEVAL
) ();

    localparam int unsigned CW = cnt_width(NEVAL);

    logic [NSTAGES-1:0] ichal;
    logic               ivalid;
    logic               oready;
    logic [NSTAGES-1:0] ochal;
    logic               olaunch;
    logic               oarbclr;
    logic               iarb;
    logic               oresp;
    logic [CW-1:0]      oones;
    logic               ovalid;
    logic               iready;

    modport slave (
        input  ichal, ivalid, iarb, iready,
        output oready, ochal, olaunch, oarbclr, oresp, oones, ovalid
    );

    modport master (
        output ichal, ivalid, iarb, iready,
        input  oready, ochal, olaunch, oarbclr, oresp, oones, ovalid
    );

endinterface

// File: rtl/settle_timer.sv
// Loadable down-counter that times the chain settle window.
// oexpire fires on the last decrement cycle, so a load of N gives N cycles of idec.
module settle_timer
    import apuf_pkg::*;
#(
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic iclk,
    input  logic irst,
    input  logic iload,
    input  logic idec,
    output logic oexpire
);

    localparam int unsigned W = cnt_width(SETTLE);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (iload) begin
            count_d = W'(SETTLE);
        end else if (idec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign oexpire = idec && (count_q == W'(1));

endmodule

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: launches NEVAL races on one challenge
// and reports the majority of the arbiter decisions.
module apuf_eval_ctrl
    import apuf_pkg::*;
#(
    parameter int unsigned NSTAGES = DEF_NSTAGES,
    parameter int unsigned NEVAL   = DEF_NEVAL,
    parameter int unsigned SETTLE  = DEF_SETTLE
) (
    input logic             iclk,
    input logic             irst,
    apuf_eval_ctrl_if.slave bus
);

    localparam int unsigned CW = cnt_width(NEVAL);

    state_e             state_q, state_d;
    logic [NSTAGES-1:0] chal_q, chal_d;
    logic [CW-1:0]      eval_q, eval_d;
    logic [CW-1:0]      ones_q, ones_d;
    logic               launch;
    logic               arbclr;
    logic               done;
    logic               expire;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .iclk    (iclk),
        .irst    (irst),
        .iload   (launch),
        .idec    (state_q == StWait),
        .oexpire (expire)
    );

    always_comb begin
        state_d = state_q;
        chal_d  = chal_q;
        eval_d  = eval_q;
        ones_d  = ones_q;
        launch  = 1'b0;
        arbclr  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.ivalid) begin
                    chal_d  = bus.ichal;
                    eval_d  = '0;
                    ones_d  = '0;
                    state_d = StPrep;
                end
            end
            StPrep:   state_d = StLaunch;
            StLaunch: begin
                launch  = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (expire) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (bus.iarb) begin
                    ones_d = ones_q + CW'(1);
                end
                eval_d  = eval_q + CW'(1);
                state_d = StClear;
            end
            StClear: begin
                arbclr  = 1'b1;
                state_d = (eval_q == CW'(NEVAL)) ? StDone : StLaunch;
            end
            StDone: begin
                done = 1'b1;
                if (bus.iready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= StIdle;
            chal_q  <= '0;
            eval_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            chal_q  <= chal_d;
            eval_q  <= eval_d;
            ones_q  <= ones_d;
        end
    end

    // Response fields read as zero outside DONE so nothing stale leaks out.
    assign bus.oready  = (state_q == StIdle) && !irst;
    assign bus.ochal   = chal_q;
    assign bus.olaunch = launch;
    assign bus.oarbclr = arbclr;
    assign bus.ovalid  = done;
    assign bus.oones   = done ? ones_q : '0;
    assign bus.oresp   = done && (ones_q > CW'(NEVAL / 2));

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed bench for apuf_eval_ctrl at default parameters (64 stages, 7 evals, settle 4).
module tb_apuf_eval_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    apuf_eval_ctrl_if #(.NSTAGES(64), .NEVAL(7)) bus ();

    apuf_eval_ctrl #(
        .NSTAGES (64),
        .NEVAL   (7),
        .SETTLE  (4)
    ) dut (
        .iclk (clk),
        .irst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts from IDLE; n counts negedges after the accepting edge.
    task automatic run_eval(input logic [63:0] chal, input logic [6:0] pat,
                            input int exp_ones, input logic exp_resp, input string tag);
        int   sched_err;
        int   pulses;
        logic exp_launch;
        logic exp_clr;
        sched_err   = 0;
        pulses      = 0;
        bus.ichal   = chal;
        bus.ivalid  = 1'b1;
        bus.iarb    = pat[0];
        for (int n = 0; n <= 50; n++) begin
            @(negedge clk);
            if (n == 0) begin
                bus.ivalid = 1'b0;
                bus.ichal  = ~chal;
                total++;
                if (bus.ochal !== chal) begin
                    bad++;
                    $display("FAIL %s_capture: ochal=%h expected %h", tag, bus.ochal, chal);
                end
            end
            exp_launch = (n >= 1) && (n < 50) && (((n - 1) % 7) == 0);
            exp_clr    = (n >= 7) && ((n % 7) == 0);
            if (bus.olaunch !== exp_launch || bus.oarbclr !== exp_clr ||
                bus.ovalid !== (n == 50) || bus.oready !== 1'b0 || bus.ochal !== chal) begin
                sched_err++;
            end
            if (bus.olaunch === 1'b1) pulses++;
            if (exp_launch) bus.iarb = pat[(n - 1) / 7];
        end
        total++;
        if (sched_err !== 0) begin
            bad++;
            $display("FAIL %s_schedule: %0d bad cycles, expected 0", tag, sched_err);
        end
        total++;
        if (pulses !== 7) begin
            bad++;
            $display("FAIL %s_launches: %0d pulses, expected 7", tag, pulses);
        end
        total++;
        if (bus.ovalid !== 1'b1) begin
            bad++;
            $display("FAIL %s_ovalid50: ovalid=%b expected 1", tag, bus.ovalid);
        end
        total++;
        if (bus.oones !== 3'(exp_ones)) begin
            bad++;
            $display("FAIL %s_oones: oones=%0d expected %0d", tag, bus.oones, exp_ones);
        end
        total++;
        if (bus.oresp !== exp_resp) begin
            bad++;
            $display("FAIL %s_oresp: oresp=%b expected %b", tag, bus.oresp, exp_resp);
        end
    endtask

    task automatic handshake(input string tag);
        bus.iready = 1'b1;
        @(negedge clk);
        bus.iready = 1'b0;
        total++;
        if (bus.ovalid !== 1'b0 || bus.oready !== 1'b1) begin
            bad++;
            $display("FAIL %s_handshake: ovalid=%b oready=%b expected 0 1",
                     tag, bus.ovalid, bus.oready);
        end
    endtask

    task automatic test_reset();
        int err;
        err = 0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.ochal !== 64'h0 || bus.olaunch !== 1'b0 || bus.oarbclr !== 1'b0 ||
                bus.oresp !== 1'b0 || bus.oones !== 3'd0 || bus.ovalid !== 1'b0 ||
                bus.oready !== 1'b0) begin
                err++;
            end
        end
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL reset_outputs: %0d bad cycles, expected 0 (ochal=%h)", err, bus.ochal);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.oready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_oready: oready=%b expected 1", bus.oready);
        end
    endtask

    task automatic test_stall();
        logic [63:0] chal;
        int          err;
        chal = 64'h0123_4567_89AB_CDEF;
        err  = 0;
        run_eval(chal, 7'b1001011, 4, 1'b1, "stall_run");
        for (int i = 0; i < 10; i++) begin
            bus.ivalid = (i % 2) == 0;
            bus.ichal  = {$urandom, $urandom};
            @(negedge clk);
            if (bus.ovalid !== 1'b1 || bus.oones !== 3'd4 || bus.oresp !== 1'b1 ||
                bus.ochal !== chal || bus.oready !== 1'b0) begin
                err++;
            end
        end
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL stall_hold: %0d bad cycles, expected 0", err);
        end
        bus.ivalid = 1'b0;
        handshake("stall");
        @(negedge clk);
        total++;
        if (bus.ochal !== chal || bus.ovalid !== 1'b0 || bus.oready !== 1'b1) begin
            bad++;
            $display("FAIL stall_no_capture: ochal=%h ovalid=%b oready=%b expected %h 0 1",
                     bus.ochal, bus.ovalid, bus.oready, chal);
        end
    endtask

    task automatic test_abort();
        int err;
        err        = 0;
        bus.ichal  = 64'hDEAD_BEEF_CAFE_F00D;
        bus.ivalid = 1'b1;
        bus.iarb   = 1'b1;
        for (int n = 0; n <= 19; n++) begin
            @(negedge clk);
            if (n == 0) bus.ivalid = 1'b0;
            if (n == 19) rst = 1'b1;
        end
        @(negedge clk);
        total++;
        if (bus.ochal !== 64'h0 || bus.ovalid !== 1'b0 || bus.olaunch !== 1'b0 ||
            bus.oarbclr !== 1'b0) begin
            bad++;
            $display("FAIL abort_state: ochal=%h ovalid=%b olaunch=%b oarbclr=%b expected 0",
                     bus.ochal, bus.ovalid, bus.olaunch, bus.oarbclr);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bus.oready !== 1'b1) begin
            bad++;
            $display("FAIL abort_oready: oready=%b expected 1", bus.oready);
        end
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.ovalid !== 1'b0) err++;
        end
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL abort_no_response: ovalid seen %0d times, expected 0", err);
        end
        run_eval(64'h0000_0000_FFFF_0001, 7'b0000000, 0, 1'b0, "after_abort");
        handshake("after_abort");
    endtask

    task automatic test_back_to_back();
        logic [63:0] c1;
        logic [63:0] c2;
        int          err;
        c1         = 64'h1111_2222_3333_4444;
        c2         = 64'h5555_6666_7777_8888;
        err        = 0;
        bus.ichal  = c1;
        bus.ivalid = 1'b1;
        bus.iready = 1'b1;
        bus.iarb   = 1'b1;
        for (int n = 0; n <= 102; n++) begin
            @(negedge clk);
            if (bus.ovalid !== ((n == 50) || (n == 102)) || bus.oready !== (n == 51) ||
                bus.ochal !== ((n <= 51) ? c1 : c2)) begin
                err++;
            end
            if (n == 52) begin
                total++;
                if (bus.ochal !== c2) begin
                    bad++;
                    $display("FAIL b2b_second_capture: ochal=%h expected %h", bus.ochal, c2);
                end
            end
            if (n == 51) bus.ichal = c2;
        end
        total++;
        if (err !== 0) begin
            bad++;
            $display("FAIL b2b_period: %0d bad cycles, expected 0", err);
        end
        bus.ivalid = 1'b0;
        @(negedge clk);
        bus.iready = 1'b0;
        total++;
        if (bus.oready !== 1'b1 || bus.ovalid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end_idle: oready=%b ovalid=%b expected 1 0",
                     bus.oready, bus.ovalid);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        bus.ichal  = '0;
        bus.ivalid = 1'b0;
        bus.iarb   = 1'b0;
        bus.iready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_eval(64'hA5A5_A5A5_A5A5_A5A5, 7'b1111111, 7, 1'b1, "all_ones");
        handshake("all_ones");
        @(negedge clk);
        test_reset();
        @(negedge clk);
        run_eval(64'h0F0F_0000_FFFF_1234, 7'b0010101, 3, 1'b0, "pat_1010100");
        handshake("pat_1010100");
        run_eval(64'h8000_0000_0000_0001, 7'b1001011, 4, 1'b1, "pat_1101001");
        handshake("pat_1101001");
        test_stall();
        test_abort();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apuf_eval_ctrl.md
APUF_EVAL_CTRL -- requirements
Module: apuf_eval_ctrl

Interface
REQ-001 Parameter NSTAGES, default 64: challenge width, equal to the number of mux stages in the delay chain.
REQ-002 Parameter NEVAL, default 7: evaluations per challenge for the majority vote; odd, at least 1.
REQ-003 Parameter SETTLE, default 4: cycles from launch to arbiter sample; at least 1.
REQ-004 iclk  in  1: sole clock; all state updates on rising edge.
REQ-005 irst  in  1: synchronous, active-high reset.
REQ-006 ichal  in  NSTAGES: challenge from requester.
REQ-007 ivalid  in  1: ichal valid.
REQ-008 oready  out  1: controller accepts a challenge this cycle.
REQ-009 ochal  out  NSTAGES: registered challenge to the mux chain; bit k drives isel of stage k.
REQ-010 olaunch  out  1: one-cycle launch edge into both chain inputs.
REQ-011 oarbclr  out  1: one-cycle clear of the arbiter latch.
REQ-012 iarb  in  1: arbiter decision bit, already synchronised.
REQ-013 oresp  out  1: majority response.
REQ-014 oones  out  clog2(NEVAL+1): count of iarb=1 samples.
REQ-015 ovalid  out  1: oresp/oones valid.
REQ-016 iready  in  1: consumer accepts the response.

Function
REQ-017 The FSM SHALL have states IDLE, PREP, LAUNCH, WAIT, SAMPLE, CLEAR and DONE; oready = (state==IDLE) && !irst.
REQ-018 IDLE: when ivalid && oready, the controller SHALL capture ichal into ochal, zero the evaluation and ones counters, and go to PREP.
REQ-019 PREP: one cycle with olaunch=0 so the mux selects settle; then go to LAUNCH.
REQ-020 LAUNCH: olaunch=1 for exactly this cycle; load the settle counter with SETTLE; then go to WAIT.
REQ-021 WAIT: decrement the settle counter each cycle and go to SAMPLE after SETTLE cycles.
REQ-022 SAMPLE: if iarb=1, increment the ones counter; increment the evaluation counter; then go to CLEAR.
REQ-023 CLEAR: oarbclr=1 for one cycle; go to DONE if the evaluation count equals NEVAL, otherwise go to LAUNCH.
REQ-024 DONE: ovalid=1, oones=ones counter, oresp=(ones > NEVAL/2), all held stable; on iready go to IDLE on the next edge.
REQ-025 ochal SHALL remain constant from capture until the DONE handshake completes.
REQ-026 ovalid SHALL rise exactly 1+NEVAL*(SETTLE+3) cycles after the accepting edge: 50 cycles at the defaults.
REQ-027 ivalid SHALL be ignored outside IDLE; there is no queuing and one challenge is in flight at most.
REQ-028 The counters SHALL never wrap; the evaluation counter saturates by construction at NEVAL.
REQ-029 A second challenge offered continuously SHALL be accepted one cycle after the DONE handshake, in IDLE.

Reset
REQ-030 While irst=1 on an edge: state IDLE, ochal=0, olaunch=0, oarbclr=0, oresp=0, oones=0, ovalid=0, all counters 0.
REQ-031 Reset asserted mid-evaluation SHALL abort it with no response produced; after reset, oready=1 on the first cycle with irst=0.

Structure
REQ-032 Package apuf_pkg SHALL hold the state enum, the default values of NSTAGES/NEVAL/SETTLE, and the helper for the width of oones.
REQ-033 One sub-module, settle_timer, SHALL implement the loadable down-counter used in WAIT; everything else is inline.

Verification
REQ-034 Reset: irst=1 for 3 cycles mid-idle -> all outputs 0; oready=1 in the first cycle after release.
REQ-035 Drive ichal=64'hA5A5_A5A5_A5A5_A5A5 with iarb=1 constant -> ochal matches; 7 olaunch pulses spaced 7 cycles apart; ovalid at +50; oresp=1; oones=7.
REQ-036 iarb samples 1,0,1,0,1,0,0 -> oones=3, oresp=0; samples 1,1,0,1,0,0,1 -> oones=4, oresp=1.
REQ-037 Hold iready=0 for 10 cycles in DONE while pulsing ivalid -> oresp, oones and ochal stable; oready=0; no second capture.
REQ-038 Assert irst at cycle 20 of an evaluation -> next cycle IDLE, ochal=0, no ovalid; a fresh challenge then completes at +50.
REQ-039 Run back-to-back with ivalid=1 and iready=1 -> the second capture occurs 1 cycle after the first handshake; period is 52 cycles.
